// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 types, constants and byte-level round functions used by the
// iterative encryption controller and its key-schedule step.
//   state_t       : 4x4 byte matrix, state[r][c] = byte 4c+r of a 128-bit word,
//                   where byte k occupies bits [127-8k -: 8]
//   fsm_e         : controller states
//   RCON          : round constants for rounds 1..10
//   sbox()        : forward S-box lookup (constant table, folds to LUTs)
//   to_state() / from_state() : 128-bit <-> matrix conversion
//   sub_bytes / shift_rows / mix_columns / add_round_key : round stages
// ---------------------------------------------------------------------------
package aes_pkg;

    typedef logic [7:0] state_t [0:3][0:3];

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } fsm_e;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Row-major S-box: entry x lives at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [2047:0] sh;
        sh = SBOX_TABLE << {x, 3'b000};
        return sh[2047:2040];
    endfunction

    // Out-of-range indices (idle/done cycles) yield zero; the value is unused then.
    function automatic logic [7:0] rcon_of(input int idx);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 1; i <= 10; i++) begin
            if (idx == i) r = RCON[i];
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic state_t to_state(input logic [127:0] v);
        state_t s;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s[r][c] = v[127 - 8 * (4 * c + r) -: 8];
            end
        end
        return s;
    endfunction

    function automatic logic [127:0] from_state(input state_t s);
        logic [127:0] v;
        v = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                v[127 - 8 * (4 * c + r) -: 8] = s[r][c];
            end
        end
        return v;
    endfunction

    function automatic state_t sub_bytes(input state_t s);
        state_t o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[r][c] = sbox(s[r][c]);
            end
        end
        return o;
    endfunction

    // Row r rotates left by r columns.
    function automatic state_t shift_rows(input state_t s);
        state_t o;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[r][c] = s[r][(c + r) % 4];
            end
        end
        return o;
    endfunction

    // Per column: b_i = a_i ^ t ^ xtime(a_i ^ a_{i+1}), t = XOR of the column.
    function automatic state_t mix_columns(input state_t s);
        state_t     o;
        logic [7:0] t;
        for (int c = 0; c < 4; c++) begin
            t = s[0][c] ^ s[1][c] ^ s[2][c] ^ s[3][c];
            for (int r = 0; r < 4; r++) begin
                o[r][c] = s[r][c] ^ t ^ xtime(s[r][c] ^ s[(r + 1) % 4][c]);
            end
        end
        return o;
    endfunction

    function automatic state_t add_round_key(input state_t s, input logic [127:0] k);
        state_t o;
        state_t ks;
        ks = to_state(k);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[r][c] = s[r][c] ^ ks[r][c];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// ---------------------------------------------------------------------------
// aes_key_step
// Combinational AES-128 key-schedule step: derives round key i from round
// key i-1 (RotWord, SubWord, RCON injection, then the word XOR chain).
//   key_in  [127:0] : previous round key (word 0 in bits [127:96])
//   rcon    [7:0]   : round constant, XORed into byte 0 of the temp word
//   key_out [127:0] : next round key
// ---------------------------------------------------------------------------
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] key_in,
    input  logic [7:0]   rcon,
    output logic [127:0] key_out
);

    logic [31:0] w_in  [0:3];
    logic [31:0] w_out [0:3];
    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] temp_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word
            assign w_in[gi]                    = key_in[127 - 32 * gi -: 32];
            assign key_out[127 - 32 * gi -: 32] = w_out[gi];
            assign sub_word[31 - 8 * gi -: 8]  = sbox(rot_word[31 - 8 * gi -: 8]);
        end
    endgenerate

    assign rot_word  = {w_in[3][23:0], w_in[3][31:24]};
    assign temp_word = sub_word ^ {rcon, 24'h000000};

    assign w_out[0] = w_in[0] ^ temp_word;
    assign w_out[1] = w_in[1] ^ w_out[0];
    assign w_out[2] = w_in[2] ^ w_out[1];
    assign w_out[3] = w_in[3] ^ w_out[2];

endmodule

// File: rtl/aes_enc_iter_ctrl.sv
// ---------------------------------------------------------------------------
// aes_enc_iter_ctrl
// Iterative AES-128 encryption sequencer: one round per clock over a shared
// round datapath, with the key schedule computed on the fly.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : plaintext+key handshake (ready only while idle)
//   in_pt, in_key     : 128-bit plaintext and cipher key, sampled at accept
//   out_valid/out_ready : ciphertext handshake
//   out_ct            : ciphertext; forced to zero whenever not valid so no
//                       intermediate round state is ever exposed
//   flush             : synchronous abort of any block in flight
//   busy              : high while a block is in flight or awaiting pickup
// Timeline: accept at edge T, rounds 1..9 on T+1..T+9, final round at T+10,
// result presented from T+10 until the output handshake.
// ---------------------------------------------------------------------------
module aes_enc_iter_ctrl
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int CNT_W = 4
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_pt,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_ct,
    input  logic         flush,
    output logic         busy
);

    generate
        if (NR != 10) begin : g_bad_nr
            $error("aes_enc_iter_ctrl: only NR=10 (AES-128) is supported");
        end
        if ((1 << CNT_W) <= NR) begin : g_bad_cnt_w
            $error("aes_enc_iter_ctrl: CNT_W too narrow for NR");
        end
    endgenerate

    fsm_e               fsm_reg,       fsm_next;
    logic [CNT_W-1:0]   round_cnt_reg, round_cnt_next;
    logic [127:0]       state_reg,     state_next;
    logic [127:0]       rkey_reg,      rkey_next;

    logic [7:0]         rcon_cur;
    logic [127:0]       rkey_step;
    logic [127:0]       round_out;
    state_t             round_sr;
    state_t             round_mc;
    state_t             round_ark;

    // Key schedule: the round key for the round being computed this cycle.
    assign rcon_cur = rcon_of(int'(round_cnt_reg));

    aes_key_step u_key_step (
        .key_in  (rkey_reg),
        .rcon    (rcon_cur),
        .key_out (rkey_step)
    );

    // Shared round datapath; mixColumns is bypassed on the final round.
    always_comb begin
        round_sr = shift_rows(sub_bytes(to_state(state_reg)));
        round_mc = mix_columns(round_sr);
        if (fsm_reg == FINAL) begin
            round_ark = add_round_key(round_sr, rkey_step);
        end else begin
            round_ark = add_round_key(round_mc, rkey_step);
        end
        round_out = from_state(round_ark);
    end

    always_comb begin
        fsm_next       = fsm_reg;
        round_cnt_next = round_cnt_reg;
        state_next     = state_reg;
        rkey_next      = rkey_reg;

        // Flush wins over any accept or output handshake on the same edge.
        if (flush) begin
            fsm_next       = IDLE;
            round_cnt_next = '0;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (in_valid) begin
                        state_next     = in_pt ^ in_key;
                        rkey_next      = in_key;
                        round_cnt_next = CNT_W'(1);
                        fsm_next       = ROUND;
                    end
                end
                ROUND: begin
                    state_next     = round_out;
                    rkey_next      = rkey_step;
                    round_cnt_next = round_cnt_reg + CNT_W'(1);
                    if (round_cnt_reg >= CNT_W'(NR - 1)) begin
                        fsm_next = FINAL;
                    end
                end
                FINAL: begin
                    state_next = round_out;
                    rkey_next  = rkey_step;
                    fsm_next   = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_next       = IDLE;
                        round_cnt_next = '0;
                    end
                end
                default: begin
                    fsm_next       = IDLE;
                    round_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg       <= IDLE;
            round_cnt_reg <= '0;
            state_reg     <= '0;
            rkey_reg      <= '0;
        end else begin
            fsm_reg       <= fsm_next;
            round_cnt_reg <= round_cnt_next;
            state_reg     <= state_next;
            rkey_reg      <= rkey_next;
        end
    end

    assign in_ready  = (fsm_reg == IDLE);
    assign out_valid = (fsm_reg == DONE);
    assign busy      = (fsm_reg != IDLE);
    assign out_ct    = out_valid ? state_reg : '0;

endmodule

// File: tb/tb_aes_enc_iter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_enc_iter_ctrl
// Self-checking bench for the iterative AES-128 controller. Known-answer
// vectors are table driven; random vectors use an independent byte-level
// AES model whose S-box is derived from the GF(2^8) inverse + affine map.
// Expected ciphertexts and accept cycles are queued at accept and popped
// when out_valid is seen.
// ---------------------------------------------------------------------------
module tb_aes_enc_iter_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         flush = 1'b0;
    logic [127:0] in_pt = '0;
    logic [127:0] in_key = '0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_ct;
    logic         busy;

    aes_enc_iter_ctrl #(.NR(10), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pt     (in_pt),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ct    (out_ct),
        .flush     (flush),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [127:0] exp_q [$];
    int           acc_q [$];
    logic [7:0]   sbox_m [256];

    typedef struct {
        string        name;
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [3];

    localparam logic [127:0] T1_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] T1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] T1_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] T2_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] T2_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] T2_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sbox_m[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc;
        logic [31:0]  tmp;
        logic [127:0] ct;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]}
                      ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int k = 0; k < 16; k++) s[k] = pt[127 - 8 * k -: 8] ^ w[k / 4][31 - 8 * (k % 4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int k = 0; k < 16; k++) s[k] = sbox_m[s[k]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4 * c + r] = s[4 * ((c + r) % 4) + r];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[4*c+0] = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int r = 0; r < 4; r++) s[4 * c + r] = t[4 * c + r];
                end
            end
            for (int k = 0; k < 16; k++) s[k] = s[k] ^ w[4 * rnd + k / 4][31 - 8 * (k % 4) -: 8];
        end
        ct = '0;
        for (int k = 0; k < 16; k++) ct[127 - 8 * k -: 8] = s[k];
        return ct;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a block; leaves in_valid high when hold is set (back-to-back mode).
    task automatic send(input logic [127:0] pt, input logic [127:0] key,
                        input logic [127:0] ct, input bit hold);
        int n;
        n = 0;
        in_pt = pt; in_key = key; in_valid = 1'b1;
        while (!in_ready && n < 60) begin
            step();
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready stayed %b, expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        step();
        if (!hold) in_valid = 1'b0;
        exp_q.push_back(ct);
        acc_q.push_back(cyc);
    endtask

    // Wait for out_valid, compare against the scoreboard head.
    task automatic recv(input string name, output int seen_cyc);
        int n;
        logic [127:0] e;
        int a;
        n = 0;
        seen_cyc = cyc;
        while (!out_valid && n < 60) begin
            step();
            n++;
        end
        if (!out_valid) begin
            tests++; fails++;
            $display("FAIL %s_timeout: out_valid stayed %b, expected 1", name, out_valid);
            return;
        end
        seen_cyc = cyc;
        if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL %s_unexpected: out_ct %h with no block outstanding", name, out_ct);
            return;
        end
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk({name, "_ct"}, out_ct, e);
        chk({name, "_latency"}, 128'(cyc - a), 128'(10));
        $display("[TB] %s ct=%h latency=%0d", name, out_ct, cyc - a);
    endtask

    logic [127:0] rnd_pt  [8];
    logic [127:0] rnd_key [8];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          sc;
        int          prev_sc;
        logic [127:0] held_ct;
        bit          bp_bad;
        bit          seen_valid;

        build_sbox();
        vecs[0] = '{"t1_fips_b",  T1_PT,  T1_KEY, T1_CT};
        vecs[1] = '{"t2_fips_c1", T2_PT,  T2_KEY, T2_CT};
        vecs[2] = '{"sp800_ecb1", 128'h6bc1bee22e409f96e93d7e117393172a,
                    T1_KEY, 128'h3ad77bb40d7a3660a89ecaf32466ef97};
        for (int i = 0; i < 8; i++) begin
            rnd_pt[i]  = {$urandom, $urandom, $urandom, $urandom};
            rnd_key[i] = {$urandom, $urandom, $urandom, $urandom};
        end

        // Reset state.
        step(); step();
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_ct", out_ct, 128'h0);
        chk("rst_busy", 128'(busy), 128'(0));
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        out_ready = 1'b1;

        // Known-answer table (T1, T2 and one more).
        for (int i = 0; i < 3; i++) begin
            send(vecs[i].pt, vecs[i].key, vecs[i].ct, 1'b0);
            recv(vecs[i].name, sc);
            step();
            chk({vecs[i].name, "_released"}, 128'(out_valid), 128'(0));
        end

        // T3: backpressure for 20 cycles, then handshake with in_valid already high.
        out_ready = 1'b0;
        send(T1_PT, T1_KEY, T1_CT, 1'b0);
        recv("t3_bp", sc);
        held_ct = out_ct;
        bp_bad  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_ct !== held_ct || in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1)
                bp_bad = 1'b1;
        end
        chk("t3_hold_stable", 128'(bp_bad), 128'(0));
        chk("t3_held_ct", out_ct, T1_CT);
        in_pt = T2_PT; in_key = T2_KEY; in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        chk("t3_after_hs_valid", 128'(out_valid), 128'(0));
        chk("t3_no_same_cycle_accept", 128'(busy), 128'(0));
        chk("t3_in_ready_next", 128'(in_ready), 128'(1));
        send(T2_PT, T2_KEY, T2_CT, 1'b0);
        recv("t3_next", sc);
        step();

        // T4: flush during round 5 of T1, flush overriding an accept, then T2.
        send(T1_PT, T1_KEY, T1_CT, 1'b0);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        chk("t4_flush_busy", 128'(busy), 128'(0));
        chk("t4_flush_in_ready", 128'(in_ready), 128'(1));
        in_pt = T1_PT; in_key = T1_KEY; in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("t4_flush_beats_accept", 128'(busy), 128'(0));
        seen_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen_valid = 1'b1;
        end
        chk("t4_no_t1_output", 128'(seen_valid), 128'(0));
        send(T2_PT, T2_KEY, T2_CT, 1'b0);
        recv("t4_t2", sc);
        step();

        // T5: asynchronous reset during round 3, then T1 again.
        send(T1_PT, T1_KEY, T1_CT, 1'b0);
        repeat (2) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", 128'(out_valid), 128'(0));
        chk("t5_rst_out_ct", out_ct, 128'h0);
        chk("t5_rst_busy", 128'(busy), 128'(0));
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        step();
        rst_n = 1'b1;
        step();
        chk("t5_in_ready", 128'(in_ready), 128'(1));
        send(T1_PT, T1_KEY, T1_CT, 1'b0);
        recv("t5_t1", sc);
        step();

        // T6: back-to-back random blocks with in_valid held high.
        // Accept-to-accept spacing: 9 rounds + final + done + one idle cycle.
        out_ready = 1'b1;
        prev_sc = 0;
        fork
            begin : driver
                for (int i = 0; i < 8; i++)
                    send(rnd_pt[i], rnd_key[i], model_enc(rnd_pt[i], rnd_key[i]), 1'b1);
                in_valid = 1'b0;
            end
            begin : receiver
                int rc_cyc;
                for (int i = 0; i < 8; i++) begin
                    recv($sformatf("t6_b2b%0d", i), rc_cyc);
                    if (i > 0) chk($sformatf("t6_gap%0d", i), 128'(rc_cyc - prev_sc), 128'(12));
                    prev_sc = rc_cyc;
                    step();
                end
            end
        join
        chk("t6_queue_drained", 128'(exp_q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
